// File: rtl/demux_stream.sv
// Registered 1-to-CHANNELS valid/ready stream demux with out-of-range drop accounting.
// Optional broadcast input enabled by defining DEMUX_STREAM_BCAST_EN.
module demux_stream #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   input  logic [SELW-1:0]              in_sel,
`ifdef DEMUX_STREAM_BCAST_EN
   input  logic                         in_bcast,
`endif
   output logic [CHANNELS-1:0]          out_valid,
   input  logic [CHANNELS-1:0]          out_ready,
   output logic [CHANNELS*WIDTH-1:0]    out_data,
   output logic                         drop_pulse,
   output logic [7:0]                   drop_count
);

   localparam logic [SELW:0] LP_CHANNELS = (SELW+1)'(CHANNELS);

   logic [WIDTH-1:0]    r_data;
   logic [CHANNELS-1:0] r_mask;
   logic                r_drop_pulse;
   logic [7:0]          r_drop_count;

   logic [CHANNELS-1:0] w_stalled;
   logic [CHANNELS-1:0] w_onehot;
   logic                w_in_range;
   logic                w_bcast;
   logic                w_accept;
   logic [CHANNELS-1:0] w_mask_nxt;
   logic [WIDTH-1:0]    w_data_nxt;
   logic                w_drop;

`ifdef DEMUX_STREAM_BCAST_EN
   assign w_bcast = in_bcast;
`else
   assign w_bcast = 1'b0;
`endif

   // Lanes still pending after this cycle's handshakes; any such lane blocks the input.
   assign w_stalled  = r_mask & ~out_ready;
   assign in_ready   = ~reset & ~(|w_stalled);
   assign w_accept   = in_valid & in_ready;
   assign w_in_range = ({1'b0, in_sel} < LP_CHANNELS);
   assign w_onehot   = {{(CHANNELS-1){1'b0}}, 1'b1} << in_sel;

   // Next holding-register and lane-mask state from accept/drain/drop.
   always_comb begin
      w_mask_nxt = w_stalled;
      w_data_nxt = r_data;
      w_drop     = 1'b0;
      if (w_accept) begin
         if (w_bcast) begin
            w_mask_nxt = {CHANNELS{1'b1}};
            w_data_nxt = in_data;
         end else if (w_in_range) begin
            w_mask_nxt = w_onehot;
            w_data_nxt = in_data;
         end else begin
            w_drop = 1'b1;
         end
      end else begin
         w_drop = 1'b0;
      end
   end

   // State registers with synchronous reset; drop counter saturates at 255.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data       <= {WIDTH{1'b0}};
         r_mask       <= {CHANNELS{1'b0}};
         r_drop_pulse <= 1'b0;
         r_drop_count <= 8'd0;
      end else begin
         r_data       <= w_data_nxt;
         r_mask       <= w_mask_nxt;
         r_drop_pulse <= w_drop;
         if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
         end else begin
            r_drop_count <= r_drop_count;
         end
      end
   end

   assign out_valid  = r_mask;
   assign drop_pulse = r_drop_pulse;
   assign drop_count = r_drop_count;

   // Unselected lanes present zero data.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      assign out_data[gi*WIDTH +: WIDTH] = r_mask[gi] ? r_data : {WIDTH{1'b0}};
   end

endmodule
